// File: rtl/apb_ranger_pkg.sv
// Shared register map, bit positions, engine state encoding and channel-scan helper
// for the multi-channel ultrasonic ranger.
package apb_ranger_pkg;

    localparam logic [7:0] ADDR_CTRL       = 8'h00;
    localparam logic [7:0] ADDR_START      = 8'h04;
    localparam logic [7:0] ADDR_STATUS     = 8'h08;
    localparam logic [7:0] ADDR_IRQ_STATUS = 8'h0C;
    localparam logic [7:0] ADDR_IRQ_EN     = 8'h10;
    localparam logic [7:0] ADDR_THRESH     = 8'h14;

    localparam int BIT_EN      = 0;
    localparam int BIT_CONT    = 1;
    localparam int BIT_MASK    = 8;
    localparam int BIT_BUSY    = 0;
    localparam int BIT_VALID   = 8;
    localparam int BIT_DONE    = 0;
    localparam int BIT_NEAR    = 8;
    localparam int BIT_TIMEOUT = 31;

    // state      | meaning
    // IDLE       | no sweep in progress
    // TRIG       | trigger pulse on selected channel
    // WAIT_RISE  | waiting for a fresh echo rising edge
    // MEASURE    | counting echo high time
    // STORE      | commit result for the channel
    // GAP        | ringdown pause before the next channel
    typedef enum logic [2:0] {
        ST_IDLE, ST_TRIG, ST_WAIT_RISE, ST_MEASURE, ST_STORE, ST_GAP
    } state_t;

    // Lowest set mask bit at index >= from; result is {found, index}.
    function automatic logic [3:0] find_ch(input logic [7:0] mask, input logic [3:0] from);
        find_ch = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) find_ch = {1'b1, 3'(i)};
        end
    endfunction

endpackage

// File: rtl/ranger_echo_sync.sv
// Two-flop synchroniser for one asynchronous echo line, with rise/fall pulses
// taken from the synchronised level.
module ranger_echo_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_echo,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta, r_sync, r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_echo;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/apb_multi_ranger.sv
// APB3 slave scanning NUM_CH ultrasonic rangers round-robin with one shared
// trigger/measure engine; results, sweep-done and near-obstacle flags in registers.
module apb_multi_ranger
    import apb_ranger_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 24,
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 4000000,
    parameter int GAP_CYCLES     = 6000000
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trigger,
    output logic              IRQ
);
    logic              r_en, r_cont, r_done, r_ien_done;
    logic [NUM_CH-1:0] r_mask, r_valid, r_near, r_ien_near, r_dist_to;
    logic [CNT_W-1:0]  r_thresh;
    logic [CNT_W-1:0]  r_dist_cnt [NUM_CH];

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_ch, w_ch_nxt;
    logic [31:0]       r_timer, w_timer_nxt;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic              r_timeout, w_to_nxt;
    logic              w_store, w_sweep_done;

    logic [NUM_CH-1:0] w_rise, w_fall, w_store_ch, w_rd_clr, w_near_clr;
    logic              w_rise_sel, w_fall_sel, w_near_hit;
    logic [7:0]        w_addr, w_mask8;
    logic [3:0]        w_first, w_next;
    logic              w_acc, w_wr, w_rd, w_is_dist, w_mapped, w_en_eff, w_start_req;
    logic              w_unused;

    assign w_addr      = {PADDR[7:2], 2'b00};
    assign w_acc       = PSEL & PENABLE;
    assign w_wr        = w_acc & PWRITE;
    assign w_rd        = w_acc & ~PWRITE;
    assign w_is_dist   = (w_addr[7:5] == 3'b001) && ({1'b0, w_addr[4:2]} < 4'(NUM_CH));
    assign w_mapped    = w_is_dist || (w_addr inside {ADDR_CTRL, ADDR_START, ADDR_STATUS,
                                                      ADDR_IRQ_STATUS, ADDR_IRQ_EN, ADDR_THRESH});
    // A write clearing EN must stop the engine on the same edge it commits.
    assign w_en_eff    = (w_wr && w_addr == ADDR_CTRL) ? PWDATA[BIT_EN] : r_en;
    assign w_start_req = w_wr && (w_addr == ADDR_START) && PWDATA[0] && r_en;
    assign w_mask8     = 8'(r_mask);
    assign w_first     = find_ch(w_mask8, 4'd0);
    assign w_next      = find_ch(w_mask8, {1'b0, r_ch} + 4'd1);
    assign w_near_hit  = !r_timeout && (r_count < r_thresh);
    assign w_near_clr  = (w_wr && w_addr == ADDR_IRQ_STATUS) ? PWDATA[BIT_NEAR +: NUM_CH] : '0;
    assign w_unused    = &{1'b0, PADDR[1:0], PWDATA};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        ranger_echo_sync u_sync (
            .i_clk  (PCLK),
            .i_rst  (PRESET),
            .i_echo (echo[g]),
            .o_rise (w_rise[g]),
            .o_fall (w_fall[g])
        );
    end

    always_comb begin
        w_rise_sel = 1'b0;
        w_fall_sel = 1'b0;
        trigger    = '0;
        w_store_ch = '0;
        w_rd_clr   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch == 3'(i)) begin
                w_rise_sel    = w_rise[i];
                w_fall_sel    = w_fall[i];
                trigger[i]    = (r_state == ST_TRIG);
                w_store_ch[i] = w_store;
            end
            w_rd_clr[i] = w_rd && w_is_dist && (w_addr[4:2] == 3'(i));
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_timer   <= '0;
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch      <= w_ch_nxt;
            r_timer   <= w_timer_nxt;
            r_count   <= w_count_nxt;
            r_timeout <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ch_nxt     = r_ch;
        w_timer_nxt  = r_timer;
        w_count_nxt  = r_count;
        w_to_nxt     = r_timeout;
        w_store      = 1'b0;
        w_sweep_done = 1'b0;
        if (r_state != ST_IDLE && !w_en_eff) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if ((w_start_req || (r_en && r_cont)) && w_first[3]) begin
                    w_state_nxt = ST_TRIG;
                    w_ch_nxt    = w_first[2:0];
                    w_timer_nxt = 32'(TRIG_CYCLES - 1);
                end
                ST_TRIG: if (r_timer == '0) begin
                    w_state_nxt = ST_WAIT_RISE;
                    w_timer_nxt = 32'(TIMEOUT_CYCLES - 1);
                end else w_timer_nxt = r_timer - 32'd1;
                ST_WAIT_RISE: if (w_rise_sel) begin
                    w_state_nxt = ST_MEASURE;
                    w_count_nxt = '0;
                    w_to_nxt    = 1'b0;
                end else if (r_timer == '0) begin
                    w_state_nxt = ST_STORE;
                    w_count_nxt = '1;
                    w_to_nxt    = 1'b1;
                end else w_timer_nxt = r_timer - 32'd1;
                ST_MEASURE: if (w_fall_sel) begin
                    w_state_nxt = ST_STORE;
                end else if (r_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = ST_STORE;
                    w_count_nxt = CNT_W'(TIMEOUT_CYCLES);
                    w_to_nxt    = 1'b1;
                end else w_count_nxt = r_count + 1'b1;
                ST_STORE: begin
                    w_store     = 1'b1;
                    w_state_nxt = ST_GAP;
                    w_timer_nxt = 32'(GAP_CYCLES - 1);
                end
                ST_GAP: if (r_timer != '0) begin
                    w_timer_nxt = r_timer - 32'd1;
                end else if (w_next[3]) begin
                    w_state_nxt = ST_TRIG;
                    w_ch_nxt    = w_next[2:0];
                    w_timer_nxt = 32'(TRIG_CYCLES - 1);
                end else begin
                    w_sweep_done = 1'b1;
                    if (r_en && r_cont && w_first[3]) begin
                        w_state_nxt = ST_TRIG;
                        w_ch_nxt    = w_first[2:0];
                        w_timer_nxt = 32'(TRIG_CYCLES - 1);
                    end else w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Hardware set beats a same-cycle W1C or read-clear.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_en <= 1'b0; r_cont <= 1'b0; r_mask <= '0; r_thresh <= '0;
            r_done <= 1'b0; r_ien_done <= 1'b0; r_ien_near <= '0;
            r_near <= '0; r_valid <= '0; r_dist_to <= '0;
            for (int i = 0; i < NUM_CH; i++) r_dist_cnt[i] <= '0;
        end else begin
            if (w_wr) begin
                case (w_addr)
                    ADDR_CTRL: begin
                        r_en   <= PWDATA[BIT_EN];
                        r_cont <= PWDATA[BIT_CONT];
                        r_mask <= PWDATA[BIT_MASK +: NUM_CH];
                    end
                    ADDR_IRQ_EN: begin
                        r_ien_done <= PWDATA[BIT_DONE];
                        r_ien_near <= PWDATA[BIT_NEAR +: NUM_CH];
                    end
                    ADDR_THRESH: r_thresh <= PWDATA[CNT_W-1:0];
                    default: ;
                endcase
            end
            r_done <= (r_done & ~(w_wr && w_addr == ADDR_IRQ_STATUS && PWDATA[BIT_DONE]))
                      | w_sweep_done;
            r_near  <= (r_near & ~w_near_clr) | (w_store_ch & {NUM_CH{w_near_hit}});
            r_valid <= (r_valid & ~w_rd_clr) | w_store_ch;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_store_ch[i]) begin
                    r_dist_cnt[i] <= r_count;
                    r_dist_to[i]  <= r_timeout;
                end
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (w_addr)
                ADDR_CTRL: begin
                    PRDATA[BIT_EN]              = r_en;
                    PRDATA[BIT_CONT]            = r_cont;
                    PRDATA[BIT_MASK +: NUM_CH]  = r_mask;
                end
                ADDR_STATUS: begin
                    PRDATA[BIT_BUSY]            = (r_state != ST_IDLE);
                    PRDATA[BIT_VALID +: NUM_CH] = r_valid;
                end
                ADDR_IRQ_STATUS: begin
                    PRDATA[BIT_DONE]            = r_done;
                    PRDATA[BIT_NEAR +: NUM_CH]  = r_near;
                end
                ADDR_IRQ_EN: begin
                    PRDATA[BIT_DONE]            = r_ien_done;
                    PRDATA[BIT_NEAR +: NUM_CH]  = r_ien_near;
                end
                ADDR_THRESH: PRDATA[CNT_W-1:0] = r_thresh;
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (w_is_dist && w_addr[4:2] == 3'(i)) begin
                            PRDATA[CNT_W-1:0]   = r_dist_cnt[i];
                            PRDATA[BIT_TIMEOUT] = r_dist_to[i];
                        end
                    end
                end
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = w_acc & ~w_mapped;
    assign IRQ     = (r_done & r_ien_done) | (|(r_near & r_ien_near));

endmodule

// File: tb/tb_apb_multi_ranger.sv
// Directed bench for apb_multi_ranger: bench-driven echo responders, a trigger
// monitor checked against an expected visit queue, and register readback checks.
module tb_apb_multi_ranger;
    localparam int TRIG = 10;
    localparam int ECHO_DELAY = 5;

    logic        PCLK = 1'b0, PRESET = 1'b1;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'h00;
    logic [31:0] PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, IRQ;
    wire  [3:0]  echo;
    logic [3:0]  trigger;

    int n_pass = 0, n_total = 0;
    int echo_width [4] = '{0, 0, 0, 0};
    int fall_cnt = 0;
    int visits = 0;
    int exp_q [$];

    apb_multi_ranger #(.NUM_CH(4), .CNT_W(24), .TRIG_CYCLES(TRIG),
                       .TIMEOUT_CYCLES(1000), .GAP_CYCLES(20)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .echo(echo), .trigger(trigger), .IRQ(IRQ));

    always #5 PCLK = ~PCLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    // width 0 means no echo: timeout flag with all-ones count.
    task automatic check_dist(input string name, input logic [31:0] act, input int width);
        int cnt;
        logic ok;
        n_total++;
        cnt = int'(act[23:0]);
        if (width == 0) ok = (act == 32'h80FF_FFFF);
        else ok = (act[31:24] == 8'h00) && (cnt >= width - 1) && (cnt <= width + 1);
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h required width %0d +/-1", name, act, width);
    endtask

    function automatic logic [31:0] exp_irq_status(input logic [3:0] mask, input int thr);
        exp_irq_status = 32'h1;
        for (int c = 0; c < 4; c++)
            if (mask[c] && echo_width[c] > 0 && echo_width[c] < thr) exp_irq_status[8+c] = 1'b1;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_resp
        logic e = 1'b0;
        assign echo[g] = e;
        initial begin
            forever begin
                @(negedge trigger[g]);
                repeat (ECHO_DELAY) @(posedge PCLK);
                #1;
                if (echo_width[g] > 0) begin
                    e = 1'b1;
                    repeat (echo_width[g]) @(posedge PCLK);
                    #1;
                    e = 1'b0;
                    fall_cnt++;
                end
            end
        end
    end

    logic [3:0] prev_trig = 4'h0;
    int hi_cnt = 0;
    always @(negedge PCLK) begin
        if (PRESET) begin
            prev_trig = 4'h0;
            hi_cnt = 0;
        end else begin
            if (trigger != 4'h0) begin
                if (prev_trig == 4'h0) begin
                    int ch;
                    int want;
                    ch = 0;
                    for (int i = 0; i < 4; i++) if (trigger[i]) ch = i;
                    check_eq("trig_onehot", 32'($onehot(trigger)), 32'd1);
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    check_eq("visit_order", 32'(ch), 32'(want));
                    visits++;
                    hi_cnt = 0;
                end
                hi_cnt++;
            end else if (prev_trig != 4'h0) begin
                check_eq("trig_width", 32'(hi_cnt), 32'(TRIG));
            end
            prev_trig = trigger;
        end
    end

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        d = PRDATA;
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        logic e;
        logic done;
        done = 1'b0;
        st = 32'h0;
        for (int k = 0; k < 1000 && !done; k++) begin
            apb_read(8'h08, st, e);
            if (!st[0]) done = 1'b1;
        end
        if (!done) check_eq("wait_idle_timeout", st, st & 32'hFFFF_FFFE);
    endtask

    task automatic wait_visits(input int n);
        int k;
        for (k = 0; k < 3000 && visits < n; k++) @(negedge PCLK);
        if (visits < n) check_eq("wait_visits_timeout", 32'(visits), 32'(n));
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [7:0]  addrs [10];
        int          base, k, old;

        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24, 8'h28, 8'h2C};
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        check_eq("rst_trigger", 32'(trigger), 32'h0);
        check_eq("rst_irq", 32'(IRQ), 32'h0);
        check_eq("pready", 32'(PREADY), 32'h1);
        for (int i = 0; i < 10; i++) begin
            apb_read(addrs[i], d, e);
            check_eq($sformatf("rst_reg_%02h", addrs[i]), d, 32'h0);
            check_eq($sformatf("rst_err_%02h", addrs[i]), 32'(e), 32'h0);
        end
        apb_read(8'h3C, d, e);
        check_eq("unmapped_data", d, 32'h0);
        check_eq("unmapped_err", 32'(e), 32'h1);

        // Single sweep, channel 0, 300-cycle echo.
        echo_width[0] = 300;
        apb_write(8'h00, 32'h0000_0101);
        exp_q.push_back(0);
        apb_write(8'h04, 32'h1);
        wait_idle(d);
        check_eq("sw1_status", d, 32'h0000_0100);
        check_eq("sw1_visits", 32'(visits), 32'd1);
        apb_read(8'h0C, d, e);
        check_eq("sw1_irq_status", d, 32'h0000_0001);
        apb_read(8'h20, d, e);
        check_dist("sw1_dist0", d, 300);
        apb_read(8'h08, d, e);
        check_eq("sw1_valid_cleared", d, 32'h0);
        apb_write(8'h0C, 32'hFFFF_FFFF);

        // Mask 0xA: channels 1 and 3, near threshold 100.
        echo_width[1] = 50;
        echo_width[3] = 500;
        apb_write(8'h14, 32'd100);
        apb_write(8'h10, 32'h0000_0200);
        apb_write(8'h00, 32'h0000_0A01);
        exp_q.push_back(1);
        exp_q.push_back(3);
        base = visits;
        apb_write(8'h04, 32'h1);
        wait_idle(d);
        check_eq("sw2_status", d, 32'h0000_0A00);
        check_eq("sw2_visits", 32'(visits - base), 32'd2);
        apb_read(8'h0C, d, e);
        check_eq("sw2_irq_status", d, exp_irq_status(4'hA, 100));
        @(negedge PCLK);
        check_eq("sw2_irq_high", 32'(IRQ), 32'(|(exp_irq_status(4'hA, 100) & 32'h200)));
        apb_read(8'h24, d, e);
        check_dist("sw2_dist1", d, 50);
        apb_read(8'h2C, d, e);
        check_dist("sw2_dist3", d, 500);
        apb_write(8'h0C, 32'h0000_0200);
        @(negedge PCLK);
        check_eq("sw2_irq_cleared", 32'(IRQ), 32'h0);
        apb_read(8'h0C, d, e);
        check_eq("sw2_irq_status_after_w1c", d, 32'h0000_0001);
        apb_write(8'h0C, 32'hFFFF_FFFF);

        // Mask 0 START is ignored.
        apb_write(8'h00, 32'h0000_0001);
        apb_write(8'h04, 32'h1);
        apb_read(8'h08, d, e);
        check_eq("mask0_not_busy", d, 32'h0);

        // Channel 2 with no echo: timeout.
        echo_width[2] = 0;
        apb_write(8'h00, 32'h0000_0401);
        exp_q.push_back(2);
        apb_write(8'h04, 32'h1);
        wait_idle(d);
        check_eq("to_status", d, 32'h0000_0400);
        apb_read(8'h28, d, e);
        check_dist("to_dist2_model", d, 0);
        check_eq("to_dist2_literal", d, 32'h80FF_FFFF);
        apb_read(8'h0C, d, e);
        check_eq("to_irq_status", d, 32'h0000_0001);
        apb_write(8'h0C, 32'hFFFF_FFFF);

        // Continuous mask 0x3, abort on the second ch1 measurement.
        echo_width[0] = 60;
        echo_width[1] = 300;
        base = visits;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
        apb_write(8'h00, 32'h0000_0303);
        wait_visits(base + 3);
        apb_write(8'h0C, 32'h0000_0001);
        wait_visits(base + 4);
        for (k = 0; k < 200 && !echo[1]; k++) @(negedge PCLK);
        check_eq("cont_echo1_seen", 32'(echo[1]), 32'h1);
        repeat (20) @(posedge PCLK);
        apb_write(8'h00, 32'h0000_0300);
        check_eq("abort_trigger", 32'(trigger), 32'h0);
        apb_read(8'h08, d, e);
        check_eq("abort_busy", d & 32'h1, 32'h0);
        apb_read(8'h0C, d, e);
        check_eq("abort_no_done", d & 32'h1, 32'h0);
        apb_read(8'h24, d, e);
        check_dist("abort_dist1_kept", d, 300);
        repeat (400) @(posedge PCLK);
        check_eq("cont_visits", 32'(visits - base), 32'd4);
        check_eq("cont_queue_empty", 32'(exp_q.size()), 32'd0);

        // DIST0 read coinciding with the ch0 STORE cycle.
        apb_read(8'h20, d, e);
        apb_write(8'h0C, 32'hFFFF_FFFF);
        echo_width[0] = 100;
        apb_write(8'h00, 32'h0000_0101);
        exp_q.push_back(0);
        old = fall_cnt;
        apb_write(8'h04, 32'h1);
        for (k = 0; k < 2000 && fall_cnt == old; k++) @(posedge PCLK);
        check_eq("store_fall_seen", 32'(fall_cnt - old), 32'd1);
        apb_read(8'h20, d, e);
        apb_read(8'h08, d, e);
        check_eq("store_read_valid_kept", d & 32'h100, 32'h100);
        apb_read(8'h20, d, e);
        check_dist("store_dist0", d, 100);
        wait_idle(d);
        check_eq("store_valid_cleared", d, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_multi_ranger.md
Name: apb_multi_ranger

Overview:
- APB3 slave that drives NUM_CH ultrasonic rangers (trigger/echo pairs) and measures echo pulse width in PCLK cycles.
- Channels are scanned round-robin in single-sweep or continuous mode.
- Results are stored in per-channel registers; a level interrupt (IRQ) signals sweep completion and near-obstacle threshold crossings.
- Sits on a CoreAPB3 slot beside the LED and switch slaves; IRQ feeds an MSS F2M_GPI input.

Parameters:
- NUM_CH, 4, number of ranger channels (1..8).
- CNT_W, 24, width of the pulse-width counter and the threshold.
- TRIG_CYCLES, 1000, trigger high time in PCLK cycles.
- TIMEOUT_CYCLES, 4000000, max cycles waiting for echo rise, and max echo high time.
- GAP_CYCLES, 6000000, idle cycles between channels (ringdown).

Ports:
- PCLK  in  1  APB/fabric clock.
- PRESET  in  1  reset, synchronous, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write.
- PADDR  in  8  byte address; bits [1:0] ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  constant 1.
- PSLVERR  out  1  error on unmapped access.
- echo  in  NUM_CH  echo inputs, asynchronous.
- trigger  out  NUM_CH  trigger outputs.
- IRQ  out  1  OR of (IRQ_STATUS & IRQ_EN).

Behaviour:
Reset and APB
- Reset (PRESET=1 at a PCLK edge): all registers 0, trigger=0, IRQ=0, FSM=IDLE.
- APB has zero wait states. A write commits on the edge where PSEL&PENABLE&PWRITE. PRDATA is combinational from PADDR while PSEL.
- PSLVERR=1 during access phase for unmapped addresses. Such writes are ignored; such reads return 0.

Register map
- 0x00 CTRL RW: [0] EN; [1] CONT; [8+NUM_CH-1:8] channel MASK.
- 0x04 START WO: writing bit0=1 while EN and IDLE begins a sweep. Ignored otherwise.
- 0x08 STATUS RO: [0] BUSY; [8+NUM_CH-1:8] VALID per channel.
- 0x0C IRQ_STATUS W1C: [0] SWEEP_DONE; [8+ch] NEAR[ch].
- 0x10 IRQ_EN RW, same bit layout as IRQ_STATUS.
- 0x14 THRESH RW: [CNT_W-1:0].
- 0x20+4*ch DIST[ch] RO: [CNT_W-1:0] count; [31] TIMEOUT flag. Reading clears VALID[ch].

Echo synchronisation
- Each echo passes a 2-FF synchroniser. Rise/fall are detected on the synchronised value, giving 2-3 cycles of latency.

FSM (one shared engine)
- IDLE: leave on START, or on EN&CONT&MASK!=0. Select the lowest masked channel.
- TRIG: trigger[ch]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE.
- WAIT_RISE: on echo rise go to MEASURE with count=0. After TIMEOUT_CYCLES go to STORE with TIMEOUT=1 and count=all-ones.
- MEASURE: count+1 per cycle while echo is high. On fall go to STORE. At TIMEOUT_CYCLES go to STORE with TIMEOUT=1.
- STORE (1 cycle): write DIST[ch], set VALID[ch]. If !TIMEOUT and count<THRESH, set NEAR[ch]. Go to GAP.
- GAP: wait GAP_CYCLES, then move to the next masked channel above ch (wrap-around). If ch was the highest masked channel, set SWEEP_DONE; then go to IDLE, or restart at the lowest masked channel if EN&CONT.
- BUSY=1 in every state except IDLE.

Boundary conditions
- MASK=0 at START: START is ignored.
- MASK changed mid-sweep: takes effect at the next channel selection.
- EN cleared mid-sweep: next cycle trigger=0 and FSM=IDLE. The current channel is not stored; SWEEP_DONE is not set.
- Counter saturates at TIMEOUT_CYCLES and never wraps.
- W1C clear on the same cycle as a hardware set: set wins.
- DIST read on the same cycle as STORE for that channel: VALID stays 1.
- Echo already high on entry to WAIT_RISE is not a rise; the engine waits for a fresh rising edge.

Decomposition:
- Package apb_ranger_pkg holds register offsets, bit positions, and the FSM state enum.
- Sub-module ranger_echo_sync: per-channel 2-FF synchroniser plus edge detector, instantiated NUM_CH times.
- Register file and FSM live in apb_multi_ranger.

Test Plan:
Bench parameters: NUM_CH=4, TRIG_CYCLES=10, TIMEOUT_CYCLES=1000, GAP_CYCLES=20.
- Reset then read all registers -> all 0, trigger=0, IRQ=0. Read 0x3C -> PRDATA=0, PSLVERR=1.
- CTRL=0x0101, START=1, echo0 high 300 cycles after trigger falls -> trigger[0] high exactly 10 cycles; DIST0=300±1, VALID0=1, SWEEP_DONE=1, BUSY=0.
- MASK=0xA, THRESH=100, IRQ_EN=0x0200; ch1 echo=50, ch3 echo=500 -> channels visited 1 then 3 only; NEAR1 set, IRQ=1; W1C 0x0200 -> IRQ=0.
- ch2 echo never rises -> DIST2 bit31=1, count=0xFFFFFF after 1000 cycles in WAIT_RISE; NEAR2 not set.
- CONT=1, MASK=0x3 -> sweeps repeat with order 0,1,0,1. Clear EN while in MEASURE on ch1 -> trigger=0 next cycle, BUSY=0, DIST1 unchanged.
- Read DIST0 on the STORE cycle of ch0 -> VALID0 stays 1; a later read clears it.
